// File: rtl/regfile_fwd_sb_pkg.sv
// Shared definitions for the forwarding register file: default sizes,
// address-width helper, zero-register constant and read-source encoding.
package regfile_fwd_sb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned ZERO_REG   = 0;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_WB,
        SRC_ARR
    } rd_src_e;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_fwd_sb_if.sv
// Decode-side read, writeback, forwarding and scoreboard signals of the
// register file; master = pipeline control, slave = register file.
interface regfile_fwd_sb_if #(
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NFWD   = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
);
    logic [NREAD-1:0]        ren;
    logic [NREAD*AW-1:0]     raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rd_stall;

    logic                    hi_re;
    logic                    lo_re;
    logic [DATA_W-1:0]       hi_rdata;
    logic [DATA_W-1:0]       lo_rdata;
    logic                    hilo_stall;

    logic                    we;
    logic [AW-1:0]           waddr;
    logic [DATA_W-1:0]       wdata;
    logic                    w_ld;
    logic                    hi_we;
    logic                    lo_we;
    logic [DATA_W-1:0]       hi_wdata;
    logic [DATA_W-1:0]       lo_wdata;

    logic [NFWD-1:0]         fwd_we;
    logic [NFWD-1:0]         fwd_hi_we;
    logic [NFWD-1:0]         fwd_lo_we;
    logic [NFWD-1:0]         fwd_rdy;
    logic [NFWD*AW-1:0]      fwd_waddr;
    logic [NFWD*DATA_W-1:0]  fwd_wdata;
    logic [NFWD*DATA_W-1:0]  fwd_hi_wdata;

    logic                    sb_set;
    logic [AW-1:0]           sb_set_addr;
    logic                    div_start;
    logic                    div_done;

    modport master (
        output ren, raddr, hi_re, lo_re,
        output we, waddr, wdata, w_ld, hi_we, lo_we, hi_wdata, lo_wdata,
        output fwd_we, fwd_hi_we, fwd_lo_we, fwd_rdy, fwd_waddr, fwd_wdata, fwd_hi_wdata,
        output sb_set, sb_set_addr, div_start, div_done,
        input  rdata, rd_stall, hi_rdata, lo_rdata, hilo_stall
    );

    modport slave (
        input  ren, raddr, hi_re, lo_re,
        input  we, waddr, wdata, w_ld, hi_we, lo_we, hi_wdata, lo_wdata,
        input  fwd_we, fwd_hi_we, fwd_lo_we, fwd_rdy, fwd_waddr, fwd_wdata, fwd_hi_wdata,
        input  sb_set, sb_set_addr, div_start, div_done,
        output rdata, rd_stall, hi_rdata, lo_rdata, hilo_stall
    );

endinterface

// File: rtl/regfile_fwd_sb_fwd_sel.sv
// One read port: youngest-stage forwarding, writeback write-through, array
// fallback, and the matching stall request.
module regfile_fwd_sb_fwd_sel
    import regfile_fwd_sb_pkg::*;
#(
    parameter int unsigned NFWD   = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   en,
    input  logic [NFWD-1:0]        match,
    input  logic [NFWD-1:0]        rdy,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   wb_match,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [DATA_W-1:0]      arr_data,
    input  logic                   busy,
    output logic [DATA_W-1:0]      rdata,
    output logic                   stall
);

    logic              found;
    logic              fwd_r;
    logic [DATA_W-1:0] fwd_d;
    rd_src_e           src;

    // Only the youngest match counts; an older ready stage never hides it.
    always_comb begin
        found = 1'b0;
        fwd_r = 1'b0;
        fwd_d = '0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!found && match[k]) begin
                found = 1'b1;
                fwd_r = rdy[k];
                fwd_d = fwd_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (!en)           src = SRC_ZERO;
        else if (found)    src = SRC_FWD;
        else if (wb_match) src = SRC_WB;
        else               src = SRC_ARR;
    end

    always_comb begin
        rdata = '0;
        stall = 1'b0;
        unique case (src)
            SRC_ZERO: rdata = '0;
            SRC_FWD: begin
                rdata = fwd_d;
                stall = !fwd_r;
            end
            SRC_WB:  rdata = wb_data;
            SRC_ARR: begin
                rdata = arr_data;
                stall = busy;
            end
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/regfile_fwd_sb.sv
// Decode-stage GPR/HI/LO register file with per-stage forwarding, a load
// scoreboard per GPR and a HI/LO busy flag for the iterative divider.
module regfile_fwd_sb
    import regfile_fwd_sb_pkg::*;
#(
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NFWD   = 3,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREG   = NREG_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    regfile_fwd_sb_if.slave bus
);

    localparam int unsigned AW = addr_w(NREG);

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [NREG-1:0]   busy;
    logic              hilo_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NREG; r++) gpr[r] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.we && bus.waddr != AW'(ZERO_REG)) gpr[bus.waddr] <= bus.wdata;
            if (bus.hi_we) hi_q <= bus.hi_wdata;
            if (bus.lo_we) lo_q <= bus.lo_wdata;
        end
    end

    // Set is written after clear so a same-cycle reissue stays outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy      <= '0;
            hilo_busy <= 1'b0;
        end else begin
            if (bus.we && bus.w_ld) busy[bus.waddr] <= 1'b0;
            if (bus.sb_set && bus.sb_set_addr != AW'(ZERO_REG)) busy[bus.sb_set_addr] <= 1'b1;
            if (bus.div_start)     hilo_busy <= 1'b1;
            else if (bus.div_done) hilo_busy <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              en;
        logic [NFWD-1:0]   match;
        logic [DATA_W-1:0] rd;
        logic              st;

        assign ra = bus.raddr[gi*AW +: AW];
        assign en = resetn && bus.ren[gi] && (ra != AW'(ZERO_REG));

        always_comb begin
            match = '0;
            for (int unsigned k = 0; k < NFWD; k++)
                match[k] = bus.fwd_we[k] && (bus.fwd_waddr[k*AW +: AW] == ra);
        end

        regfile_fwd_sb_fwd_sel #(.NFWD(NFWD), .DATA_W(DATA_W)) u_sel (
            .en       (en),
            .match    (match),
            .rdy      (bus.fwd_rdy),
            .fwd_data (bus.fwd_wdata),
            .wb_match (bus.we && (bus.waddr == ra)),
            .wb_data  (bus.wdata),
            .arr_data (gpr[ra]),
            .busy     (busy[ra]),
            .rdata    (rd),
            .stall    (st)
        );

        assign bus.rdata[gi*DATA_W +: DATA_W] = rd;
        assign bus.rd_stall[gi]               = st;
    end

    logic hi_st;
    logic lo_st;

    regfile_fwd_sb_fwd_sel #(.NFWD(NFWD), .DATA_W(DATA_W)) u_hi_sel (
        .en       (resetn && bus.hi_re),
        .match    (bus.fwd_hi_we),
        .rdy      (bus.fwd_rdy),
        .fwd_data (bus.fwd_hi_wdata),
        .wb_match (bus.hi_we),
        .wb_data  (bus.hi_wdata),
        .arr_data (hi_q),
        .busy     (hilo_busy),
        .rdata    (bus.hi_rdata),
        .stall    (hi_st)
    );

    regfile_fwd_sb_fwd_sel #(.NFWD(NFWD), .DATA_W(DATA_W)) u_lo_sel (
        .en       (resetn && bus.lo_re),
        .match    (bus.fwd_lo_we),
        .rdy      (bus.fwd_rdy),
        .fwd_data (bus.fwd_wdata),
        .wb_match (bus.lo_we),
        .wb_data  (bus.lo_wdata),
        .arr_data (lo_q),
        .busy     (hilo_busy),
        .rdata    (bus.lo_rdata),
        .stall    (lo_st)
    );

    assign bus.hilo_stall = hi_st | lo_st;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: directed stimulus queues expected
// values, a negedge monitor pops and compares them against the outputs.
module tb_regfile_fwd_sb;

    localparam int unsigned NREAD = 2;
    localparam int unsigned NFWD  = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;

    localparam int K_RDATA = 0;
    localparam int K_STALL = 1;
    localparam int K_HI    = 2;
    localparam int K_LO    = 3;
    localparam int K_HLST  = 4;

    logic clk;
    logic resetn;

    regfile_fwd_sb_if #(.NREAD(NREAD), .NFWD(NFWD), .DATA_W(DW), .AW(AW)) bus ();

    regfile_fwd_sb #(.NREAD(NREAD), .NFWD(NFWD), .DATA_W(DW), .NREG(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t        e;
    logic [31:0] act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_RDATA: act = bus.rdata[e.port*DW +: DW];
                K_STALL: act = {31'd0, bus.rd_stall[e.port]};
                K_HI:    act = bus.hi_rdata;
                K_LO:    act = bus.lo_rdata;
                default: act = {31'd0, bus.hilo_stall};
            endcase
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, act, e.val);
            end
        end
    end

    task automatic chk(input string n, input int kind, input int port, input logic [31:0] v);
        exp_t x;
        x.name = n;
        x.kind = kind;
        x.port = port;
        x.val  = v;
        q.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ren = '0;          bus.raddr = '0;
        bus.hi_re = 1'b0;      bus.lo_re = 1'b0;
        bus.we = 1'b0;         bus.waddr = '0;      bus.wdata = '0;   bus.w_ld = 1'b0;
        bus.hi_we = 1'b0;      bus.lo_we = 1'b0;
        bus.hi_wdata = '0;     bus.lo_wdata = '0;
        bus.fwd_we = '0;       bus.fwd_hi_we = '0;  bus.fwd_lo_we = '0; bus.fwd_rdy = '0;
        bus.fwd_waddr = '0;    bus.fwd_wdata = '0;  bus.fwd_hi_wdata = '0;
        bus.sb_set = 1'b0;     bus.sb_set_addr = '0;
        bus.div_start = 1'b0;  bus.div_done = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.ren[p] = 1'b1;
        bus.raddr[p*AW +: AW] = a;
    endtask

    task automatic fwd(input int k, input logic [AW-1:0] a, input logic [31:0] d, input logic r);
        bus.fwd_we[k] = 1'b1;
        bus.fwd_waddr[k*AW +: AW] = a;
        bus.fwd_wdata[k*DW +: DW] = d;
        bus.fwd_rdy[k] = r;
    endtask

    task automatic fwd_hi(input int k, input logic [31:0] d, input logic r);
        bus.fwd_hi_we[k] = 1'b1;
        bus.fwd_hi_wdata[k*DW +: DW] = d;
        bus.fwd_rdy[k] = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        // Reset state: forwarded data must not leak out while in reset.
        rd(0, 5'd7); fwd(0, 5'd7, 32'h99, 1'b0);
        bus.hi_re = 1'b1; fwd_hi(1, 32'h98, 1'b0);
        chk("rst_rdata0", K_RDATA, 0, 32'h0);
        chk("rst_stall0", K_STALL, 0, 32'h0);
        chk("rst_hi",     K_HI,    0, 32'h0);
        chk("rst_hlst",   K_HLST,  0, 32'h0);

        // 1: write r5, write-through then array read; r0 always zero
        step(); idle(); resetn = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF; rd(0, 5'd5);
        chk("t1_wthru", K_RDATA, 0, 32'hDEADBEEF);
        step(); idle();
        rd(0, 5'd5); rd(1, 5'd0); fwd(0, 5'd0, 32'h1234, 1'b0);
        chk("t1_arr",       K_RDATA, 0, 32'hDEADBEEF);
        chk("t1_arr_stall", K_STALL, 0, 32'h0);
        chk("t1_r0",        K_RDATA, 1, 32'h0);
        chk("t1_r0_stall",  K_STALL, 1, 32'h0);

        // 2: youngest stage wins; its not-ready flag stalls
        step(); idle();
        rd(0, 5'd7); fwd(0, 5'd7, 32'h11, 1'b1); fwd(2, 5'd7, 32'h22, 1'b1);
        chk("t2_young",       K_RDATA, 0, 32'h11);
        chk("t2_young_stall", K_STALL, 0, 32'h0);
        step(); idle();
        rd(0, 5'd7); rd(1, 5'd7); fwd(0, 5'd7, 32'h11, 1'b0); fwd(2, 5'd7, 32'h22, 1'b1);
        chk("t2_nrdy_stall0", K_STALL, 0, 32'h1);
        chk("t2_nrdy_stall1", K_STALL, 1, 32'h1);
        chk("t2_nrdy_data",   K_RDATA, 0, 32'h11);
        step(); idle();
        rd(0, 5'd7); fwd(0, 5'd8, 32'h11, 1'b0); fwd(2, 5'd7, 32'h22, 1'b1);
        chk("t2_old",       K_RDATA, 0, 32'h22);
        chk("t2_old_stall", K_STALL, 0, 32'h0);

        // 3: load scoreboard on r9
        step(); idle(); bus.sb_set = 1'b1; bus.sb_set_addr = 5'd9;
        step(); idle();
        step(); idle();
        step(); idle();
        rd(1, 5'd9);
        chk("t3_busy_stall", K_STALL, 1, 32'h1);
        chk("t3_busy_data",  K_RDATA, 1, 32'h0);
        step(); idle();
        rd(1, 5'd9); bus.we = 1'b1; bus.w_ld = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h55;
        chk("t3_wb_data",  K_RDATA, 1, 32'h55);
        chk("t3_wb_stall", K_STALL, 1, 32'h0);
        step(); idle();
        rd(1, 5'd9);
        chk("t3_clr_data",  K_RDATA, 1, 32'h55);
        chk("t3_clr_stall", K_STALL, 1, 32'h0);

        // 4: same-cycle set and clear of r9 leaves it busy
        step(); idle();
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd9;
        bus.we = 1'b1; bus.w_ld = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h66; rd(0, 5'd9);
        chk("t4_wb_data",  K_RDATA, 0, 32'h66);
        chk("t4_wb_stall", K_STALL, 0, 32'h0);
        step(); idle();
        rd(0, 5'd9);
        chk("t4_setwins_stall", K_STALL, 0, 32'h1);
        chk("t4_setwins_data",  K_RDATA, 0, 32'h66);

        // 5: divider busy flag and HI/LO forwarding
        step(); idle(); bus.div_start = 1'b1;
        step(); idle(); bus.hi_re = 1'b1;
        chk("t5_hi_busy", K_HLST, 0, 32'h1);
        chk("t5_hi_zero", K_HI,   0, 32'h0);
        step(); idle(); bus.lo_re = 1'b1;
        chk("t5_lo_busy", K_HLST, 0, 32'h1);
        step(); idle(); bus.hi_re = 1'b1; fwd_hi(0, 32'h77, 1'b1);
        chk("t5_hi_fwd",       K_HI,   0, 32'h77);
        chk("t5_hi_fwd_stall", K_HLST, 0, 32'h0);
        step(); idle(); bus.hi_re = 1'b1; fwd_hi(1, 32'h78, 1'b0); fwd_hi(2, 32'h79, 1'b1);
        chk("t5_hi_nrdy",       K_HLST, 0, 32'h1);
        chk("t5_hi_nrdy_data",  K_HI,   0, 32'h78);
        step(); idle();
        bus.div_done = 1'b1; bus.hi_we = 1'b1; bus.hi_wdata = 32'hA;
        bus.lo_we = 1'b1; bus.lo_wdata = 32'hB; bus.hi_re = 1'b1; bus.lo_re = 1'b1;
        chk("t5_wb_hi",    K_HI,   0, 32'hA);
        chk("t5_wb_lo",    K_LO,   0, 32'hB);
        chk("t5_wb_stall", K_HLST, 0, 32'h0);
        step(); idle(); bus.hi_re = 1'b1; bus.lo_re = 1'b1;
        chk("t5_arr_hi",    K_HI,   0, 32'hA);
        chk("t5_arr_lo",    K_LO,   0, 32'hB);
        chk("t5_arr_stall", K_HLST, 0, 32'h0);
        step(); idle(); bus.lo_re = 1'b1; bus.fwd_lo_we[1] = 1'b1;
        bus.fwd_wdata[1*DW +: DW] = 32'h88; bus.fwd_rdy[1] = 1'b1;
        chk("t5_lo_fwd", K_LO, 0, 32'h88);
        step(); idle(); bus.div_start = 1'b1; bus.div_done = 1'b1;
        step(); idle(); bus.hi_re = 1'b1;
        chk("t5_startdone_stall", K_HLST, 0, 32'h1);
        chk("t5_startdone_hi",    K_HI,   0, 32'hA);

        // 6: reset mid-operation with r12 busy and HI/LO busy
        step(); idle(); bus.sb_set = 1'b1; bus.sb_set_addr = 5'd12;
        step(); idle(); resetn = 1'b0;
        rd(0, 5'd12); rd(1, 5'd5); fwd(0, 5'd5, 32'h1, 1'b0);
        bus.hi_re = 1'b1; fwd_hi(0, 32'h5, 1'b0);
        chk("t6_in_rdata0", K_RDATA, 0, 32'h0);
        chk("t6_in_rdata1", K_RDATA, 1, 32'h0);
        chk("t6_in_stall0", K_STALL, 0, 32'h0);
        chk("t6_in_stall1", K_STALL, 1, 32'h0);
        chk("t6_in_hi",     K_HI,    0, 32'h0);
        chk("t6_in_hlst",   K_HLST,  0, 32'h0);
        step(); idle(); resetn = 1'b1;
        rd(0, 5'd12); rd(1, 5'd5); bus.hi_re = 1'b1; bus.lo_re = 1'b1;
        chk("t6_post_rdata0", K_RDATA, 0, 32'h0);
        chk("t6_post_stall0", K_STALL, 0, 32'h0);
        chk("t6_post_rdata1", K_RDATA, 1, 32'h0);
        chk("t6_post_hi",     K_HI,    0, 32'h0);
        chk("t6_post_lo",     K_LO,    0, 32'h0);
        chk("t6_post_hlst",   K_HLST,  0, 32'h0);

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
- Parametrised successor to the core GPR/HI/LO register file.
- N read ports; forwarding from NFWD pipeline stages with per-stage data-ready flags.
- Load-pending scoreboard per GPR and a HI/LO busy flag for the iterative divider.
- Produces per-port stall requests consumed by the decode-stage hazard logic; sits in decode, written from writeback.

Parameters:
NREAD, 2, number of GPR read ports
NFWD, 3, number of forwarding stages (index 0 = youngest, e.g. EX; NFWD-1 = oldest)
DATA_W, 32, register width
NREG, 32, number of GPRs; AW = clog2(NREG); register 0 hard-wired to zero

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ren  in  NREAD  per-port read enable
raddr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rdata  out  NREAD*DATA_W  packed read data
rd_stall  out  NREAD  per-port stall request
hi_re / lo_re  in  1 each  HI / LO read enable
hi_rdata / lo_rdata  out  DATA_W each  HI / LO read data
hilo_stall  out  1  HI or LO read must stall
we, waddr, wdata  in  1, AW, DATA_W  writeback GPR write
w_ld  in  1  writeback write is a load result (clears scoreboard)
hi_we, lo_we  in  1 each  writeback HI / LO write
hi_wdata, lo_wdata  in  DATA_W each  writeback HI / LO data (independent, so mult writes both)
fwd_we, fwd_hi_we, fwd_lo_we, fwd_rdy  in  NFWD each  per-stage write flags and data-valid
fwd_waddr  in  NFWD*AW  per-stage destination
fwd_wdata, fwd_hi_wdata  in  NFWD*DATA_W each  per-stage GPR/LO data and HI data
sb_set, sb_set_addr  in  1, AW  load issued to register sb_set_addr
div_start, div_done  in  1 each  divider issued / result delivered

Behaviour:
- Reset (resetn low, asynchronous): all GPRs, HI, LO, busy[NREG], hilo_busy cleared to 0. While in reset, rdata, hi_rdata and lo_rdata read 0; stalls are 0.
- GPR write: on posedge clk when we and waddr != 0. HI/LO write when hi_we/lo_we. Writes to register 0 are ignored.
- GPR read, combinational, priority per port i:
  - ren=0 or raddr=0 → 0.
  - Youngest matching fwd stage k (fwd_we[k] and fwd_waddr[k]==raddr) → its fwd_wdata.
  - Writeback write-through (we and waddr==raddr) → wdata.
  - Otherwise the array.
- HI read, same priority: hi_re=0 → 0; youngest fwd_hi_we → fwd_hi_wdata; hi_we → hi_wdata; else HI. LO is identical using fwd_lo_we / fwd_wdata / lo_wdata.
- rd_stall[i] = ren[i] and raddr!=0, and either:
  - the selected (youngest) matching stage has fwd_rdy=0, or
  - no stage matches, no writeback write-through matches, and busy[raddr]=1.
  Older stages never mask a not-ready younger match.
- hilo_stall = (hi_re or lo_re) and, for the enabled register(s), either:
  - the youngest matching stage has fwd_rdy=0, or
  - no stage or writeback match and hilo_busy=1.
- Scoreboard update on posedge clk:
  - sb_set and sb_set_addr!=0 → busy set.
  - we and w_ld → busy[waddr] cleared.
  - Same address set and clear in one cycle → set wins (newer load outstanding).
  - Clear of a non-busy entry → no effect. sb_set to register 0 is ignored.
- hilo_busy: div_start sets, div_done clears; both in one cycle → stays set. A second div_start while busy keeps it set.
- Latency: reads and stalls are zero-cycle combinational; state updates are visible the cycle after the edge (write-through covers the same-cycle writeback).
- Reset mid-operation clears the scoreboard; any pending load or div result is discarded by the pipeline flush.

Decomposition:
- Shared package (defines.vh): DATA_W and NREG defaults, AW derivation, zero-register constant.
- One sub-module, fwd_sel: one-read-port priority forwarding/stall mux, parametrised on NFWD. Instantiated NREAD times for GPRs and twice for HI/LO (with busy input).

Test Plan:
1. Reset, then write r5=0xDEADBEEF; next cycle ren0, raddr0=5 → rdata0=0xDEADBEEF, rd_stall0=0. raddr=0 with fwd_we to 0 → 0.
2. fwd stage0 and stage2 both target r7 (0x11, 0x22), both rdy → 0x11. Stage0 rdy=0 → rd_stall=1 even though stage2 is ready.
3. sb_set r9, three idle cycles: read r9 → stall=1. Writeback we, w_ld, r9=0x55 → same cycle rdata=0x55, stall=0; next cycle busy clear.
4. Same cycle sb_set r9 and w_ld clear r9 → busy[9]=1 afterwards; read with no forward → stall.
5. div_start; hi_re → hilo_stall=1 until div_done plus writeback hi_we=0xA, lo_we=0xB → hi_rdata=0xA, lo_rdata=0xB, stall=0.
6. Assert resetn low mid-sequence with busy entries set → all outputs 0 immediately; after release, reads return 0 with no stalls.
